// File: rtl/register_file_pkg.sv
// Sizing constants shared by the register file and its storage element.
package register_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/constant_values.vh
// Shared word-level constants for the MIPS datapath.
`ifndef CONSTANT_VALUES_VH
`define CONSTANT_VALUES_VH

`define WORD_ZERO 32'h0000_0000
`define ZERO_REG  5'd0

`endif

// File: rtl/register_file_register_32_bit.sv
// One 32-bit architectural register: synchronous active-high clear, load on ld.
`include "constant_values.vh"

module register_32_bit
    import register_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out
);

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= `WORD_ZERO;
        end else if (ld == 1'b1) begin
            out <= in;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32 MIPS register file: two combinational read ports with WB->ID bypass,
// one synchronous write port, register 0 hardwired to zero.
`include "constant_values.vh"

module register_file
    import register_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    word_t              reg_q [NUM_REGS];
    logic [NUM_REGS-1:1] ld;
    logic               write_en;

    // An X on reg_write or write_reg makes the compare X, which the if treats
    // as false, so no entry is loaded in simulation.
    always_comb begin
        write_en = 1'b0;
        if (!rst && reg_write == 1'b1 && write_reg != `ZERO_REG) begin
            write_en = 1'b1;
        end
    end

    assign reg_q[0] = `WORD_ZERO;

    // NOTE: the register array is reset explicitly through each element's
    // synchronous clear, so it maps onto flops rather than a RAM macro.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
        localparam reg_addr_t IDX = ADDR_WIDTH'(i);

        always_comb begin
            ld[i] = 1'b0;
            if (write_en == 1'b1 && write_reg == IDX) begin
                ld[i] = 1'b1;
            end
        end

        register_32_bit u_reg (
            .clk (clk),
            .rst (rst),
            .ld  (ld[i]),
            .in  (write_data),
            .out (reg_q[i])
        );
    end

    function automatic word_t read_port(input reg_addr_t addr);
        word_t data;
        data = `WORD_ZERO;
        if (rst) begin
            data = `WORD_ZERO;
        end else if (addr == `ZERO_REG) begin
            data = `WORD_ZERO;
        end else if (write_en == 1'b1 && addr == write_reg) begin
            data = write_data;
        end else begin
            data = reg_q[addr];
        end
        return data;
    endfunction

    // NOTE: defaults are assigned first in every combinational path so no
    // output can hold a previous value and infer a latch.
    always_comb begin
        read_data_1 = read_port(read_reg_1);
        read_data_2 = read_port(read_reg_2);
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;

    int n_compared;
    int n_mismatched;

    register_file dut (
        .clk         (clk),
        .rst         (rst),
        .read_reg_1  (read_reg_1),
        .read_reg_2  (read_reg_2),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .reg_write   (reg_write),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled
    // well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        logic [31:0] exp_1;
        logic [31:0] exp_2;
        logic [4:0]  other;

        n_compared   = 0;
        n_mismatched = 0;

        // Reset with a competing write that must be dropped.
        rst        = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'hDEAD_BEEF;
        read_reg_1 = 5'd5;
        read_reg_2 = 5'd5;
        settle();
        check("rst_rd1_during", read_data_1, 32'h0);
        check("rst_rd2_during", read_data_2, 32'h0);
        tick();
        rst        = 1'b0;
        reg_write  = 1'b0;
        read_reg_1 = 5'd5;
        read_reg_2 = 5'd31;
        settle();
        check("rst_r5_after", read_data_1, 32'h0);
        check("rst_r31_after", read_data_2, 32'h0);

        // Basic write then read.
        reg_write  = 1'b1;
        write_reg  = 5'd8;
        write_data = 32'h1234_5678;
        read_reg_1 = 5'd1;
        read_reg_2 = 5'd2;
        tick();
        reg_write  = 1'b0;
        read_reg_1 = 5'd8;
        read_reg_2 = 5'd0;
        settle();
        check("basic_r8", read_data_1, 32'h1234_5678);
        check("basic_r0", read_data_2, 32'h0);

        // Register 0 ignores writes and never bypasses.
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'hFFFF_FFFF;
        read_reg_1 = 5'd0;
        read_reg_2 = 5'd0;
        settle();
        check("r0_rd1_during", read_data_1, 32'h0);
        check("r0_rd2_during", read_data_2, 32'h0);
        tick();
        reg_write = 1'b0;
        settle();
        check("r0_rd1_after", read_data_1, 32'h0);
        check("r0_rd2_after", read_data_2, 32'h0);

        // Bypass on both ports over an old value of 1.
        reg_write  = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'h0000_0001;
        tick();
        write_data = 32'hA5A5_A5A5;
        read_reg_1 = 5'd9;
        read_reg_2 = 5'd9;
        settle();
        check("byp_rd1_same", read_data_1, 32'hA5A5_A5A5);
        check("byp_rd2_same", read_data_2, 32'hA5A5_A5A5);
        tick();
        reg_write = 1'b0;
        settle();
        check("byp_rd1_after", read_data_1, 32'hA5A5_A5A5);
        check("byp_rd2_after", read_data_2, 32'hA5A5_A5A5);

        // Disabled write: no bypass, no state change.
        reg_write  = 1'b0;
        write_reg  = 5'd10;
        write_data = 32'hCAFE_BABE;
        read_reg_1 = 5'd10;
        read_reg_2 = 5'd9;
        settle();
        check("dis_r10_same", read_data_1, 32'h0);
        check("dis_r9_same", read_data_2, 32'hA5A5_A5A5);
        tick();
        settle();
        check("dis_r10_next", read_data_1, 32'h0);

        // Sweep: r = index * 0x01010101, then read pairs (r, 32 - r).
        reg_write = 1'b1;
        for (int r = 1; r < 32; r++) begin
            write_reg  = 5'(r);
            write_data = 32'(r) * 32'h0101_0101;
            tick();
        end
        reg_write = 1'b0;
        for (int r = 1; r < 32; r++) begin
            other      = 5'(32 - r);
            read_reg_1 = 5'(r);
            read_reg_2 = other;
            exp_1      = 32'(r) * 32'h0101_0101;
            exp_2      = 32'(32 - r) * 32'h0101_0101;
            settle();
            check($sformatf("sweep_rd1_r%0d", r), read_data_1, exp_1);
            check($sformatf("sweep_rd2_r%0d", 32 - r), read_data_2, exp_2);
        end

        // Bypass hits only the matching port.
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 32'h0BAD_F00D;
        read_reg_1 = 5'd3;
        read_reg_2 = 5'd4;
        settle();
        check("byp_one_hit", read_data_1, 32'h0BAD_F00D);
        check("byp_one_miss", read_data_2, 32'h0404_0404);

        // Reset clears a populated array.
        tick();
        reg_write = 1'b0;
        rst       = 1'b1;
        tick();
        rst        = 1'b0;
        read_reg_1 = 5'd3;
        read_reg_2 = 5'd31;
        settle();
        check("rst2_r3", read_data_1, 32'h0);
        check("rst2_r31", read_data_2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
